// File: rtl/spart_pkg.sv
// Shared definitions for the mini SPART receive/host glue.
//   ADDR_*      : host register map (data, status, divisor low, divisor high)
//   rx_state_e  : receiver frame state
package spart_pkg;

  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DIVL = 2'b10;
  localparam logic [1:0] ADDR_DIVH = 2'b11;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/spart_baud_gen.sv
// Programmable baud generator: 16-bit divisor register plus a down-counter
// that emits a one-cycle oversampling tick every divisor+1 clocks.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   wr_lo_i       : write wdata_i into divisor[7:0]
//   wr_hi_i       : write wdata_i into divisor[15:8]
//   wdata_i       : host write data
//   divisor_o     : current divisor (host read-back)
//   baud_en_o     : registered oversampling tick
module spart_baud_gen #(
  parameter logic [15:0] DIV_RST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [7:0]  wdata_i,
  output logic [15:0] divisor_o,
  output logic        baud_en_o
);

  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic        baud_q, baud_d;

  always_comb begin
    div_d = div_q;
    if (wr_lo_i) div_d[7:0]  = wdata_i;
    if (wr_hi_i) div_d[15:8] = wdata_i;

    cnt_d  = cnt_q - 16'd1;
    baud_d = 1'b0;
    // A divisor write restarts the period from the freshly written value.
    if (wr_lo_i || wr_hi_i) begin
      cnt_d = div_d;
    end else if (cnt_q == 16'd0) begin
      baud_d = 1'b1;
      cnt_d  = div_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= DIV_RST;
      cnt_q  <= DIV_RST;
      baud_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      baud_q <= baud_d;
    end
  end

  assign divisor_o = div_q;
  assign baud_en_o = baud_q;

endmodule

// File: rtl/spart_rx_core.sv
// Receive half and host-side glue of the mini SPART: bus decode, baud
// generator and an 8N1 receiver sampling on a 16x (OVS) oversampling tick.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   iocs, iorw, ioaddr : host bus strobe, 1=read/0=write, register select
//   databus_in         : host write data
//   databus_out        : host read data (8'h00 when not reading)
//   databus_sel        : read cycle in progress (host bus tri-state enable)
//   tbr                : transmit buffer ready from the external transmitter
//   tx_data, wrt_tx    : write data and load strobe to the external transmitter
//   baud_en            : oversampling tick shared with the transmitter
//   RxD                : serial input, idle high
//   rda                : received byte available
// Optional build macro SPART_FRAME_ERR_EN adds a sticky frame-error flag
// (stop bit sampled low) visible as status bit 2, cleared by a status read.
module spart_rx_core
  import spart_pkg::*;
#(
  parameter logic [15:0] DIV_RST = 16'h0000,
  parameter int          OVS     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] databus_in,
  output logic [7:0] databus_out,
  output logic       databus_sel,
  input  logic       tbr,
  output logic [7:0] tx_data,
  output logic       wrt_tx,
  output logic       baud_en,
  input  logic       RxD,
  output logic       rda
);

  localparam int              TW     = $clog2(OVS);
  localparam logic [TW-1:0]   T_HALF = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0]   T_LAST = TW'(OVS - 1);

  // Host bus decode
  logic wrt_db_low, wrt_db_high, rd_rx;

  assign wrt_db_low  = iocs & ~iorw & (ioaddr == ADDR_DIVL);
  assign wrt_db_high = iocs & ~iorw & (ioaddr == ADDR_DIVH);
  assign rd_rx       = iocs &  iorw & (ioaddr == ADDR_DATA);
  assign wrt_tx      = iocs & ~iorw & (ioaddr == ADDR_DATA);
  assign databus_sel = iocs &  iorw;
  assign tx_data     = databus_in;

  logic [15:0] divisor;

  spart_baud_gen #(
    .DIV_RST (DIV_RST)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .wr_lo_i   (wrt_db_low),
    .wr_hi_i   (wrt_db_high),
    .wdata_i   (databus_in),
    .divisor_o (divisor),
    .baud_en_o (baud_en)
  );

  // Receiver state
  rx_state_e     state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rda_q, rda_d;
  logic          stop_sample;

  assign stop_sample = baud_en & (state_q == RX_STOP) & (tcnt_q == T_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RX_IDLE;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      rda_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      rda_q     <= rda_d;
    end
  end

  // Next-state logic: the frame only advances on oversampling ticks.
  always_comb begin
    state_d = state_q;
    if (baud_en) begin
      case (state_q)
        RX_IDLE:  if (!RxD) state_d = RX_START;
        // Mid-start-bit check rejects line glitches shorter than half a bit.
        RX_START: if (tcnt_q == T_HALF) state_d = RxD ? RX_IDLE : RX_DATA;
        RX_DATA:  if (tcnt_q == T_LAST && bcnt_q == 3'd7) state_d = RX_STOP;
        RX_STOP:  if (tcnt_q == T_LAST) state_d = RX_IDLE;
        default:  state_d = RX_IDLE;
      endcase
    end
  end

  // Counters, shift register and receive buffer.
  always_comb begin
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    if (baud_en) begin
      case (state_q)
        RX_IDLE: tcnt_d = '0;
        RX_START: begin
          if (tcnt_q == T_HALF) begin
            tcnt_d = '0;
            bcnt_d = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (tcnt_q == T_LAST) begin
            tcnt_d  = '0;
            shift_d = {RxD, shift_q[7:1]};  // LSB arrives first
            bcnt_d  = bcnt_q + 3'd1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (tcnt_q == T_LAST) begin
            tcnt_d    = '0;
            rx_data_d = shift_q;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        default: tcnt_d = '0;
      endcase
    end
    // A completing byte wins over a simultaneous data read.
    if (stop_sample)  rda_d = 1'b1;
    else if (rd_rx)   rda_d = 1'b0;
    else              rda_d = rda_q;
  end

  logic [7:0] status;

`ifdef SPART_FRAME_ERR_EN
  logic ferr_q, ferr_d;
  logic rd_stat;

  assign rd_stat = iocs & iorw & (ioaddr == ADDR_STAT);

  always_comb begin
    if (stop_sample && !RxD) ferr_d = 1'b1;
    else if (rd_stat)        ferr_d = 1'b0;
    else                     ferr_d = ferr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ferr_q <= 1'b0;
    else     ferr_q <= ferr_d;
  end

  assign status = {5'b0, ferr_q, tbr, rda_q};
`else
  assign status = {6'b0, tbr, rda_q};
`endif

  // Read mux
  always_comb begin
    databus_out = 8'h00;
    if (databus_sel) begin
      case (ioaddr)
        ADDR_DATA: databus_out = rx_data_q;
        ADDR_STAT: databus_out = status;
        ADDR_DIVL: databus_out = divisor[7:0];
        default:   databus_out = divisor[15:8];
      endcase
    end
  end

  assign rda = rda_q;

endmodule

// File: tb/tb_spart_rx_core.sv
// Bench for spart_rx_core: a tick/frame-level reference model checked every
// cycle, plus hand-computed expectations for the register map and frames.
module tb_spart_rx_core;

  localparam int          OVS     = 16;
  localparam logic [15:0] DIV_RST = 16'h0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] databus_in = 8'h00;
  logic       tbr = 1'b0;
  logic       RxD = 1'b1;
  logic [7:0] databus_out;
  logic       databus_sel;
  logic [7:0] tx_data;
  logic       wrt_tx;
  logic       baud_en;
  logic       rda;

  spart_rx_core #(.DIV_RST(DIV_RST), .OVS(OVS)) dut (
    .clk         (clk),
    .rst         (rst),
    .iocs        (iocs),
    .iorw        (iorw),
    .ioaddr      (ioaddr),
    .databus_in  (databus_in),
    .databus_out (databus_out),
    .databus_sel (databus_sel),
    .tbr         (tbr),
    .tx_data     (tx_data),
    .wrt_tx      (wrt_tx),
    .baud_en     (baud_en),
    .RxD         (RxD),
    .rda         (rda)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Baud: tick in the cycle after every (div+1)-th edge since the last
  // divisor write or reset. Receiver: ticks counted from start detection;
  // start checked at OVS/2, bit i at OVS/2 + OVS*(i+1), stop at OVS/2 + 9*OVS.
  logic [15:0] m_div;
  int          m_n;
  bit          m_baud;
  bit          m_busy;
  int          m_k;
  int          m_idx;
  logic [7:0]  m_shift;
  logic [7:0]  m_rxdata;
  bit          m_rda;
  bit          m_done;
  bit          m_live = 1'b0;
  bit          m_wl, m_wh, m_rd;
`ifdef SPART_FRAME_ERR_EN
  bit          m_ferr;
  bit          m_bad;
`endif

  always @(posedge clk) begin
    if (rst) begin
      m_div = DIV_RST; m_n = 0; m_baud = 1'b0;
      m_busy = 1'b0; m_k = 0; m_shift = 8'h00; m_rxdata = 8'h00; m_rda = 1'b0;
`ifdef SPART_FRAME_ERR_EN
      m_ferr = 1'b0;
`endif
      m_live = 1'b1;
    end else if (m_live) begin
      m_wl = iocs && !iorw && ioaddr == 2'b10;
      m_wh = iocs && !iorw && ioaddr == 2'b11;
      m_rd = iocs && iorw && ioaddr == 2'b00;
      m_done = 1'b0;
`ifdef SPART_FRAME_ERR_EN
      m_bad = 1'b0;
`endif
      if (m_baud) begin
        if (!m_busy) begin
          if (RxD == 1'b0) begin m_busy = 1'b1; m_k = 0; end
        end else begin
          m_k++;
          if (m_k == OVS/2) begin
            if (RxD) m_busy = 1'b0;
          end else if (m_k > OVS/2 && (m_k - OVS/2) % OVS == 0) begin
            m_idx = (m_k - OVS/2) / OVS;
            if (m_idx <= 8) m_shift[m_idx-1] = RxD;
            else begin
              m_done = 1'b1;
              m_busy = 1'b0;
`ifdef SPART_FRAME_ERR_EN
              m_bad = !RxD;
`endif
            end
          end
        end
      end
      if (m_done) begin m_rxdata = m_shift; m_rda = 1'b1; end
      else if (m_rd) m_rda = 1'b0;
`ifdef SPART_FRAME_ERR_EN
      if (m_done && m_bad) m_ferr = 1'b1;
      else if (iocs && iorw && ioaddr == 2'b01) m_ferr = 1'b0;
`endif
      if (m_wl || m_wh) begin
        if (m_wl) m_div[7:0]  = databus_in;
        if (m_wh) m_div[15:8] = databus_in;
        m_n = 0; m_baud = 1'b0;
      end else begin
        m_n++;
        m_baud = (m_n % (int'(m_div) + 1)) == 0;
      end
    end
  end

  function automatic logic [7:0] exp_out();
    logic [7:0] st;
`ifdef SPART_FRAME_ERR_EN
    st = {5'b0, m_ferr, tbr, m_rda};
`else
    st = {6'b0, tbr, m_rda};
`endif
    if (!(iocs && iorw)) return 8'h00;
    case (ioaddr)
      2'b00:   return m_rxdata;
      2'b01:   return st;
      2'b10:   return m_div[7:0];
      default: return m_div[15:8];
    endcase
  endfunction

  always @(negedge clk) begin
    if (m_live && !rst) begin
      check("baud_en", baud_en, m_baud);
      check("rda", rda, m_rda);
      check("databus_sel", databus_sel, iocs & iorw);
      check("databus_out", databus_out, exp_out());
      check("tx_data", tx_data, databus_in);
      check("wrt_tx", wrt_tx, iocs & ~iorw & (ioaddr == 2'b00));
    end
  end

  // ---------------- stimulus helpers (phase: posedge + 1) ----------------
  int cur_div = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; databus_in = d;
    tick(1);
    iocs = 1'b0; iorw = 1'($urandom); ioaddr = 2'($urandom); databus_in = 8'($urandom);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] v, output logic s);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1;
    v = databus_out; s = databus_sel;
    tick(1);
    iocs = 1'b0; iorw = 1'($urandom); ioaddr = 2'($urandom); databus_in = 8'($urandom);
  endtask

  task automatic set_div(input logic [15:0] d);
    bus_write(2'b10, d[7:0]);
    bus_write(2'b11, d[15:8]);
    cur_div = int'(d);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopv);
    int bc;
    bc = OVS * (cur_div + 1);
    RxD = 1'b0; tick(bc);
    for (int i = 0; i < 8; i++) begin RxD = b[i]; tick(bc); end
    RxD = stopv; tick(bc);
    RxD = 1'b1; tick(bc + bc / 2);
  endtask

  logic [7:0] v;
  logic       s;
  int         cnt;
  logic [7:0] rb;

  initial begin
    tick(3);
    rst = 1'b0;
    tick(1);

    check("reset_rda", rda, 1'b0);
    tbr = 1'b0;
    bus_read(2'b01, v, s);
    check("reset_status", v, 8'h00);
    bus_read(2'b00, v, s);
    check("reset_rx_data", v, 8'h00);

    // Divisor 3 -> one tick every 4 clocks.
    set_div(16'h0003);
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      cnt += int'(baud_en);
    end
    tick(0);
    @(posedge clk); #1;
    check("baud_count_24clk", 16'(cnt), 16'd5);
    bus_read(2'b10, v, s);
    check("divl_readback", v, 8'h03);
    check("divl_read_sel", s, 1'b1);

    // Overwrite of the low half.
    bus_write(2'b10, 8'h80);
    bus_write(2'b10, 8'h25);
    bus_read(2'b10, v, s);
    check("divl_overwrite", v, 8'h25);
    bus_read(2'b11, v, s);
    check("divh_readback", v, 8'h00);
    set_div(16'h0003);

    // Frame 0xA5.
    send_frame(8'hA5, 1'b1);
    check("a5_rda_set", rda, 1'b1);
    bus_read(2'b00, v, s);
    check("a5_data", v, 8'hA5);
    check("a5_sel", s, 1'b1);
    check("a5_rda_cleared", rda, 1'b0);

    // Status with tbr/rda both set, then both clear.
    send_frame(8'h11, 1'b1);
    tbr = 1'b1;
    bus_read(2'b01, v, s);
    check("status_11", v, 8'h03);
    bus_read(2'b00, v, s);
    tbr = 1'b0;
    bus_read(2'b01, v, s);
    check("status_00", v, 8'h00);

    // Short low glitch is rejected, then 0x3C arrives intact.
    RxD = 1'b0; tick(4 * (cur_div + 1));
    RxD = 1'b1; tick(2 * OVS * (cur_div + 1));
    check("glitch_rda", rda, 1'b0);
    send_frame(8'h3C, 1'b1);
    bus_read(2'b00, v, s);
    check("after_glitch_data", v, 8'h3C);

    // Reset in the middle of a frame.
    RxD = 1'b0; tick(OVS * (cur_div + 1));
    for (int i = 0; i < 4; i++) begin RxD = i[0]; tick(OVS * (cur_div + 1)); end
    rst = 1'b1; tick(1);
    rst = 1'b0; RxD = 1'b1; cur_div = int'(DIV_RST);
    tick(1);
    check("midframe_rst_rda", rda, 1'b0);
    tick(2 * OVS);
    send_frame(8'h5A, 1'b1);
    bus_read(2'b00, v, s);
    check("after_rst_data", v, 8'h5A);

    // Overrun: second byte replaces the first, rda stays set.
    set_div(16'h0001);
    send_frame(8'hE7, 1'b1);
    send_frame(8'h42, 1'b1);
    check("overrun_rda", rda, 1'b1);
    bus_read(2'b00, v, s);
    check("overrun_data", v, 8'h42);

`ifdef SPART_FRAME_ERR_EN
    send_frame(8'hC3, 1'b0);
    bus_read(2'b01, v, s);
    check("ferr_set", v[2], 1'b1);
    bus_read(2'b01, v, s);
    check("ferr_cleared", v[2], 1'b0);
    bus_read(2'b00, v, s);
    check("ferr_data", v, 8'hC3);
`endif

    // Randomised frames, divisors, tbr and interleaved register reads.
    for (int it = 0; it < 14; it++) begin
      set_div(16'($urandom_range(0, 3)));
      tbr = 1'($urandom);
      rb = 8'($urandom);
      send_frame(rb, ($urandom_range(0, 5) != 0));
      bus_read(2'($urandom), v, s);
      tick($urandom_range(0, 6));
      bus_read(2'b00, v, s);
      check("rand_frame_data", v, rb);
      if ($urandom_range(0, 1) == 1) begin
        RxD = 1'b0; tick($urandom_range(1, 6) * (cur_div + 1));
        RxD = 1'b1; tick(2 * OVS * (cur_div + 1));
      end
    end

    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
